// File: rtl/gin_seq_pkg.sv
// gin_seq_pkg: state encoding and counter width shared by gin_sequencer and its bench.
package gin_seq_pkg;

  localparam int XFER_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROG = 2'd1,
    ST_RUN  = 2'd2
  } gin_state_e;

endpackage

// File: rtl/gin_out_reg.sv
// gin_out_reg: one-entry valid/ready register holding the beat presented to gin_bus.
// A held beat reloads in the same cycle it is delivered, giving one beat per cycle.
module gin_out_reg #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              en_i,
  input  logic              hold_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [TAG_W-1:0]  in_tag_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic              out_fire_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic [DATA_W-1:0] out_data_o
);

  logic              vld_q, vld_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load;

  assign out_fire_o = vld_q && out_ready_i;
  assign in_ready_o = en_i && !hold_i && (!vld_q || out_ready_i);
  assign load       = in_valid_i && in_ready_o;

  always_comb begin
    vld_d  = vld_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (load) begin
      vld_d  = 1'b1;
      tag_d  = in_tag_i;
      data_d = in_data_i;
    end else if (out_fire_o) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      vld_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign out_valid_o = vld_q;
  assign out_tag_o   = tag_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/gin_sequencer.sv
// gin_sequencer: programs the gin_bus tag-ID scan chain, then streams tagged beats onto the bus.
// Optional stall counter output enabled by defining GIN_SEQ_STALL_CNT_EN.
//   state   | meaning
//   ST_IDLE | waiting for cfg_start, bus quiet
//   ST_PROG | shifting NUM_CONTROLLERS scan tags into the chain
//   ST_RUN  | forwarding in_* beats to the bus under unit_ready
module gin_sequencer
  import gin_seq_pkg::*;
#(
  parameter int BITWIDTH        = 16,
  parameter int TAG_LENGTH      = 4,
  parameter int NUM_CONTROLLERS = 10
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [TAG_LENGTH-1:0] cfg_tag,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TAG_LENGTH-1:0] in_tag,
  input  logic [BITWIDTH-1:0]   in_data,
  input  logic                  stop,
  input  logic                  unit_ready,
  output logic                  bus_program,
  output logic                  bus_enable,
  output logic [TAG_LENGTH-1:0] bus_scan_tag,
  output logic [TAG_LENGTH-1:0] bus_tag,
  output logic [BITWIDTH-1:0]   bus_value,
  output logic                  bus_unit_ready,
  output logic                  busy,
  output logic [XFER_CNT_W-1:0] xfer_count
`ifdef GIN_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  localparam int SCAN_W = $clog2(NUM_CONTROLLERS);

  gin_state_e            state_q, state_d;
  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic                  prog_q, prog_d;
  logic [TAG_LENGTH-1:0] scan_tag_q, scan_tag_d;
  logic                  run;
  logic                  cfg_acc;
  logic                  last_beat;
  logic                  out_vld;
  logic                  out_fire;
  logic [TAG_LENGTH-1:0] out_tag;
  logic [BITWIDTH-1:0]   out_data;

  assign run       = (state_q == ST_RUN);
  assign cfg_ready = (state_q == ST_PROG);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign last_beat = (scan_cnt_q == SCAN_W'(NUM_CONTROLLERS - 1));

  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    xfer_cnt_d = xfer_cnt_q;
    prog_d     = 1'b0;
    scan_tag_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d    = ST_PROG;
          scan_cnt_d = '0;
          xfer_cnt_d = '0;
        end
      end
      ST_PROG: begin
        if (cfg_acc) begin
          prog_d     = 1'b1;
          scan_tag_d = cfg_tag;
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
          // leaving PROG on the last beat drops cfg_ready before another beat can be taken
          if (last_beat) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (out_fire) xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(1);
        if (stop && (!out_vld || out_fire)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q    <= ST_IDLE;
      scan_cnt_q <= '0;
      xfer_cnt_q <= '0;
      prog_q     <= 1'b0;
      scan_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
      prog_q     <= prog_d;
      scan_tag_q <= scan_tag_d;
    end
  end

  gin_out_reg #(
    .TAG_W  (TAG_LENGTH),
    .DATA_W (BITWIDTH)
  ) u_out_reg (
    .clk         (clk),
    .rstb        (rstb),
    .en_i        (run),
    .hold_i      (stop),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_tag_i    (in_tag),
    .in_data_i   (in_data),
    .out_ready_i (unit_ready),
    .out_valid_o (out_vld),
    .out_fire_o  (out_fire),
    .out_tag_o   (out_tag),
    .out_data_o  (out_data)
  );

`ifdef GIN_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_IDLE && cfg_start) begin
      stall_cnt_d = '0;
    end else if (run && out_vld && !unit_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`endif

  assign bus_program    = prog_q;
  assign bus_scan_tag   = scan_tag_q;
  assign bus_enable     = out_vld;
  assign bus_tag        = out_tag;
  assign bus_value      = out_data;
  assign bus_unit_ready = run && unit_ready;
  assign busy           = (state_q != ST_IDLE);
  assign xfer_count     = xfer_cnt_q;

endmodule

// File: tb/tb_gin_sequencer.sv
// tb_gin_sequencer: randomized and directed checks of gin_sequencer against a queue-based model.
module tb_gin_sequencer;

  localparam int BW = 16;
  localparam int TW = 4;
  localparam int NC = 10;

  logic          clk = 1'b0;
  logic          rstb, cfg_start, cfg_valid, cfg_ready;
  logic [TW-1:0] cfg_tag;
  logic          in_valid, in_ready;
  logic [TW-1:0] in_tag;
  logic [BW-1:0] in_data;
  logic          stop, unit_ready;
  logic          bus_program, bus_enable, bus_unit_ready, busy;
  logic [TW-1:0] bus_scan_tag, bus_tag;
  logic [BW-1:0] bus_value;
  logic [15:0]   xfer_count;
`ifdef GIN_SEQ_STALL_CNT_EN
  logic [15:0]   stall_count;
`endif

  gin_sequencer #(
    .BITWIDTH        (BW),
    .TAG_LENGTH      (TW),
    .NUM_CONTROLLERS (NC)
  ) dut (
    .clk            (clk),
    .rstb           (rstb),
    .cfg_start      (cfg_start),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_tag        (cfg_tag),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_tag         (in_tag),
    .in_data        (in_data),
    .stop           (stop),
    .unit_ready     (unit_ready),
    .bus_program    (bus_program),
    .bus_enable     (bus_enable),
    .bus_scan_tag   (bus_scan_tag),
    .bus_tag        (bus_tag),
    .bus_value      (bus_value),
    .bus_unit_ready (bus_unit_ready),
    .busy           (busy),
    .xfer_count     (xfer_count)
`ifdef GIN_SEQ_STALL_CNT_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference model: phase 0=idle 1=programming 2=running, held beats in a queue
  typedef struct packed {
    logic [TW-1:0] t;
    logic [BW-1:0] d;
  } beat_t;

  int            m_state = 0;
  bit            m_init = 0;
  bit            m_just_rst = 0;
  int            m_scan = 0;
  logic [15:0]   m_xfer = '0;
  logic [15:0]   m_stall = '0;
  bit            m_pulse = 0;
  logic [TW-1:0] m_ptag = '0;
  beat_t         m_q[$];
  logic [TW-1:0] obs_chain[NC];
  int            obs_pulses = 0;
  logic [TW-1:0] prog_tags[NC];

  task automatic step();
    bit    exp_in_rdy, had, deliver, accept;
    beat_t b;
    @(negedge clk);
    exp_in_rdy = (m_state == 2) && !stop && (m_q.size() == 0 || unit_ready);
    if (m_init) begin
      chk("busy", busy, m_state != 0);
      chk("cfg_ready", cfg_ready, m_state == 1);
      chk("in_ready", in_ready, exp_in_rdy);
      chk("bus_program", bus_program, m_pulse);
      chk("bus_scan_tag", bus_scan_tag, m_pulse ? m_ptag : '0);
      chk("bus_enable", bus_enable, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("bus_tag", bus_tag, m_q[0].t);
        chk("bus_value", bus_value, m_q[0].d);
      end else if (m_just_rst) begin
        chk("rst_bus_tag", bus_tag, 0);
        chk("rst_bus_value", bus_value, 0);
      end
      if (m_state == 2) chk("bus_unit_ready", bus_unit_ready, unit_ready);
      else if (m_just_rst) chk("rst_bus_unit_ready", bus_unit_ready, 0);
      chk("xfer_count", xfer_count, m_xfer);
`ifdef GIN_SEQ_STALL_CNT_EN
      chk("stall_count", stall_count, m_stall);
`endif
    end
    if (bus_program === 1'b1) begin
      for (int k = NC - 1; k > 0; k--) obs_chain[k] = obs_chain[k-1];
      obs_chain[0] = bus_scan_tag;
      obs_pulses++;
    end
    m_just_rst = 0;
    m_pulse    = 0;
    m_ptag     = '0;
    if (rstb) begin
      m_init     = 1;
      m_just_rst = 1;
      m_state    = 0;
      m_scan     = 0;
      m_xfer     = '0;
      m_stall    = '0;
      m_q.delete();
    end else begin
      case (m_state)
        0: if (cfg_start) begin
          m_state = 1;
          m_scan  = 0;
          m_xfer  = '0;
          m_stall = '0;
        end
        1: if (cfg_valid) begin
          m_pulse = 1;
          m_ptag  = cfg_tag;
          m_scan++;
          if (m_scan == NC) m_state = 2;
        end
        default: begin
          had     = m_q.size() != 0;
          deliver = had && unit_ready;
          accept  = in_valid && exp_in_rdy;
          if (had && !unit_ready && m_stall != 16'hFFFF) m_stall++;
          if (deliver) begin
            void'(m_q.pop_front());
            m_xfer++;
          end
          if (accept) begin
            b.t = in_tag;
            b.d = in_data;
            m_q.push_back(b);
          end
          if (stop && (!had || deliver)) m_state = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // full programming session from IDLE; patterned uses valid gaps 1,0,1,1,0 repeating
  task automatic do_program(input bit patterned);
    int       idx = 0;
    int       n = 0;
    bit       acc;
    logic [4:0] pat = 5'b01101;
    cfg_start  = 1'b1;
    obs_pulses = 0;
    step();
    cfg_start = 1'b0;
    while (m_state == 1 && n < 200) begin
      cfg_valid = patterned ? pat[n % 5] : ($urandom_range(0, 2) != 0);
      cfg_tag   = prog_tags[idx];
      acc       = cfg_valid;
      step();
      n++;
      if (acc) idx++;
    end
    if (n >= 200) chk("prog_timeout_cycles", n, 0);
    cfg_valid = 1'b1;
    cfg_tag   = 4'hF;
    step();
    step();
    cfg_valid = 1'b0;
    chk("prog_pulses", obs_pulses, NC);
    for (int i = 0; i < NC; i++) chk("chain", obs_chain[NC-1-i], prog_tags[i]);
  endtask

  task automatic do_reset();
    unit_ready = 1'b0;
    rstb = 1'b1;
    step();
    rstb = 1'b0;
    step();
  endtask

  initial begin
    rstb = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_tag = '0;
    in_valid = 0; in_tag = '0; in_data = '0; stop = 0; unit_ready = 0;
    for (int k = 0; k < NC; k++) obs_chain[k] = '0;
    step();
    do_reset();

    // reset part-way through programming
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1;
      cfg_tag   = TW'($urandom);
      step();
    end
    cfg_valid = 1'b0;
    do_reset();
    chk("rst_prog_busy", busy, 0);
    chk("rst_prog_cfg_ready", cfg_ready, 0);

    for (int i = 0; i < NC; i++) prog_tags[i] = TW'(NC - 1 - i);
    do_program(1'b1);
    for (int k = 0; k < NC; k++) chk("chain_id", obs_chain[k], k);

    // back-to-back beats with the bus ready
    unit_ready = 1'b1;
    in_valid = 1'b1; in_tag = 4'd3; in_data = 16'd13; step();
    in_tag = 4'd1; in_data = 16'd11; step();
    in_tag = 4'd9; in_data = 16'd19; step();
    in_valid = 1'b0;
    step();
    step();
    chk("xfer_three", xfer_count, 3);

    // backpressure for five cycles
    unit_ready = 1'b0;
    in_valid = 1'b1; in_tag = 4'd3; in_data = 16'd13; step();
    in_tag = 4'd5; in_data = 16'd7;
    repeat (5) step();
    chk("bp_tag", bus_tag, 3);
    chk("bp_value", bus_value, 13);
`ifdef GIN_SEQ_STALL_CNT_EN
    chk("bp_stall_five", stall_count, 5);
`endif
    unit_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();

    // cfg_start while running is ignored
    cfg_start = 1'b1;
    step();
    step();
    cfg_start = 1'b0;
    chk("cfg_start_run_busy", busy, 1);
    chk("cfg_start_run_xfer", xfer_count, 5);

    // stop with a held beat under backpressure
    unit_ready = 1'b0;
    in_valid = 1'b1; in_tag = 4'd6; in_data = 16'hBEEF; step();
    in_valid = 1'b0;
    stop = 1'b1;
    repeat (3) step();
    chk("stop_held_busy", busy, 1);
    unit_ready = 1'b1;
    step();
    stop = 1'b0;
    unit_ready = 1'b0;
    step();
    chk("stop_idle_busy", busy, 0);
    chk("stop_xfer", xfer_count, 6);

    // randomized sessions, the last one cut short by reset
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < NC; i++) prog_tags[i] = TW'($urandom);
      do_program(1'b0);
      for (int c = 0; c < 300; c++) begin
        in_valid   = $urandom_range(0, 1) != 0;
        in_tag     = TW'($urandom);
        in_data    = BW'($urandom);
        unit_ready = $urandom_range(0, 3) != 0;
        cfg_start  = $urandom_range(0, 15) == 0;
        if (s == 2 && c == 150) break;
        step();
      end
      cfg_start = 1'b0;
      in_valid  = 1'b0;
      if (s == 2) begin
        do_reset();
        chk("rst_run_busy", busy, 0);
        chk("rst_run_xfer", xfer_count, 0);
      end else begin
        stop = 1'b1;
        for (int c = 0; c < 100 && m_state != 0; c++) begin
          unit_ready = $urandom_range(0, 1) != 0;
          step();
        end
        if (m_state != 0) chk("drain_timeout_busy", busy, 0);
        stop = 1'b0;
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
